// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the tp1 core data port and a host/debug port; the CPU has priority.
// Define DMEM_ARB_STATS_EN to build the stall-cycle and host-ack statistics counters.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int HOST_MAX_BURST = 4,
    parameter int HOST_MAX_WAIT  = 8
) (
    input  logic              _iClk,
    input  logic              _iReset,
    input  logic              _iCpuAccess,
    input  logic              _iCpuWrite,
    input  logic [ADDR_W-1:0] _iCpuAddr,
    input  logic [DATA_W-1:0] _iCpuWData,
    output logic [DATA_W-1:0] _oCpuRData,
    output logic              _oCpuStall,
    input  logic              _iHostReq,
    input  logic              _iHostWrite,
    input  logic [ADDR_W-1:0] _iHostAddr,
    input  logic [DATA_W-1:0] _iHostWData,
    output logic              _oHostAck,
    output logic [DATA_W-1:0] _oHostRData,
    output logic [ADDR_W-1:0] _oMemAddr,
    output logic [DATA_W-1:0] _oMemWData,
    output logic              _oMemWrite,
    input  logic [DATA_W-1:0] _iMemRData,
    output logic [15:0]       _oStallCount,
    output logic [15:0]       _oHostCount
);

    localparam int WCNT_W = $clog2(HOST_MAX_WAIT + 1);
    localparam int BCNT_W = $clog2(HOST_MAX_BURST + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(HOST_MAX_WAIT - 1);
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(HOST_MAX_BURST - 1);

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    owner_t            state;
    owner_t            state_next;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_next;
    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] bcnt_next;

    always_ff @(posedge _iClk or posedge _iReset) begin
        if (_iReset) begin
            state <= OWN_CPU;
            wcnt  <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            bcnt  <= bcnt_next;
        end
    end

    // A grant always leaves OWN_CPU for at least the cycle after a release, since the
    // decision to regrant is only taken at an edge while already in OWN_CPU.
    always_comb begin
        state_next = state;
        wcnt_next  = '0;
        bcnt_next  = bcnt;
        _oHostAck  = 1'b0;
        _oCpuStall = 1'b0;
        _oMemAddr  = _iCpuAddr;
        _oMemWData = _iCpuWData;
        _oMemWrite = _iCpuAccess & _iCpuWrite;
        case (state)
            OWN_CPU: begin
                bcnt_next = '0;
                if (_iHostReq) begin
                    if (!_iCpuAccess || (wcnt == WAIT_LAST)) begin
                        state_next = OWN_HOST;
                    end else begin
                        wcnt_next = wcnt + WCNT_W'(1);
                    end
                end
            end
            OWN_HOST: begin
                _oHostAck  = _iHostReq;
                _oCpuStall = _iCpuAccess;
                _oMemAddr  = _iHostAddr;
                _oMemWData = _iHostWData;
                _oMemWrite = _iHostReq & _iHostWrite;
                if (!_iHostReq || (bcnt == BURST_LAST)) begin
                    state_next = OWN_CPU;
                    bcnt_next  = '0;
                end else begin
                    bcnt_next = bcnt + BCNT_W'(1);
                end
            end
            default: begin
                state_next = OWN_CPU;
                bcnt_next  = '0;
            end
        endcase
    end

    assign _oCpuRData  = _iMemRData;
    assign _oHostRData = _iMemRData;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] host_count;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge _iClk or posedge _iReset) begin
        if (_iReset) begin
            stall_count <= '0;
            host_count  <= '0;
        end else begin
            if (_oCpuStall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (_oHostAck && (host_count != 16'hFFFF)) begin
                host_count <= host_count + 16'd1;
            end
        end
    end

    assign _oStallCount = stall_count;
    assign _oHostCount  = host_count;
`else
    assign _oStallCount = 16'd0;
    assign _oHostCount  = 16'd0;
`endif

endmodule
